// File: rtl/rv32v_types_pkg.sv
// Shared types for the rv32v vector load return path: lane count,
// element-width encoding and deserializer state encoding.
package rv32v_types_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } vsew_t;

  typedef enum logic [1:0] {
    DS_IDLE    = 2'd0,
    DS_COLLECT = 2'd1,
    DS_DONE    = 2'd2
  } deser_state_t;

endpackage

// File: rtl/rv32v_elem_extract.sv
// Combinational element extraction: picks a byte/halfword/word out of an
// aligned LSC load word by element width and byte offset, zero-extended.
module rv32v_elem_extract
  import rv32v_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  boff,
  input  vsew_t       eew,
  output logic [31:0] elem
);

  always_comb begin
    elem = '0;
    case (eew)
      SEW8:    elem = {24'd0, rdata[{boff, 3'b000} +: 8]};
      SEW16:   elem = boff[1] ? {16'd0, rdata[31:16]} : {16'd0, rdata[15:0]};
      default: elem = rdata;
    endcase
  end

endmodule

// File: rtl/rv32v_mem_deserializer.sv
// Collects per-lane LSC load responses into a lane vector and pulses
// completion once every unmasked lane has returned. RV32V_DESER_CHECK_EN
// enables the sticky protocol-error flag and duplicate-response protection.
module rv32v_mem_deserializer
  import rv32v_types_pkg::*;
#(
  parameter  int NUM_LANES = rv32v_types_pkg::NUM_LANES,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        vstart,
  input  logic                        vflush,
  input  logic [NUM_LANES-1:0]        vlane_mask,
  input  vsew_t                       veew,
  input  logic [4:0]                  vuop_num,
  input  logic                        lsc_rvalid,
  input  logic [LANE_W-1:0]           lsc_lane,
  input  logic [31:0]                 lsc_rdata,
  input  logic [1:0]                  lsc_boff,
  output logic [NUM_LANES-1:0][31:0]  vlane_load_data,
  output logic [NUM_LANES-1:0]        vlane_wen,
  output logic [4:0]                  vuop_num_out,
  output logic                        vload_done,
  output logic                        vdeser_busy,
  output logic                        vdeser_err
);

  deser_state_t         state;
  vsew_t                eew_q;
  logic [NUM_LANES-1:0] received;
  logic [NUM_LANES-1:0] lane_bit;
  logic [NUM_LANES-1:0] recv_next;
  logic [31:0]          elem;
  logic                 lane_unmasked;
  logic                 lane_seen;
  logic                 wr_ok;
  logic                 all_in;

  rv32v_elem_extract u_extract (
    .rdata (lsc_rdata),
    .boff  (lsc_boff),
    .eew   (eew_q),
    .elem  (elem)
  );

  always_comb begin
    lane_bit           = '0;
    lane_bit[lsc_lane] = 1'b1;
  end

  assign lane_unmasked = vlane_wen[lsc_lane];
  assign lane_seen     = received[lsc_lane];

`ifdef RV32V_DESER_CHECK_EN
  // A repeated response must not clobber the first value that arrived.
  assign wr_ok = lane_unmasked && !lane_seen;
`else
  assign wr_ok = lane_unmasked;
`endif

  assign recv_next   = wr_ok ? (received | lane_bit) : received;
  assign all_in      = &(recv_next | ~vlane_wen);
  assign vdeser_busy = (state == DS_COLLECT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= DS_IDLE;
      eew_q           <= SEW8;
      received        <= '0;
      vlane_load_data <= '0;
      vlane_wen       <= '0;
      vuop_num_out    <= '0;
      vload_done      <= 1'b0;
    end else begin
      vload_done <= 1'b0;
      if (vflush) begin
        state    <= DS_IDLE;
        received <= '0;
      end else begin
        case (state)
          DS_IDLE, DS_DONE: begin
            if (vstart) begin
              vlane_wen       <= vlane_mask;
              eew_q           <= veew;
              vuop_num_out    <= vuop_num;
              received        <= '0;
              vlane_load_data <= '0;
              if (vlane_mask == '0) begin
                state      <= DS_DONE;
                vload_done <= 1'b1;
              end else begin
                state <= DS_COLLECT;
              end
            end else begin
              state <= DS_IDLE;
            end
          end
          DS_COLLECT: begin
            if (lsc_rvalid) begin
              if (wr_ok) begin
                vlane_load_data[lsc_lane] <= elem;
                received                  <= recv_next;
              end
              // Completion counts the response arriving this cycle.
              if (all_in) begin
                state      <= DS_DONE;
                vload_done <= 1'b1;
              end
            end
          end
          default: state <= DS_IDLE;
        endcase
      end
    end
  end

`ifdef RV32V_DESER_CHECK_EN
  logic err_hit;

  assign err_hit = lsc_rvalid &&
                   ((state != DS_COLLECT) || !lane_unmasked || lane_seen ||
                    ((eew_q == SEW16) && lsc_boff[0]));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vdeser_err <= 1'b0;
    end else if (err_hit) begin
      vdeser_err <= 1'b1;
    end
  end
`else
  assign vdeser_err = 1'b0;
`endif

endmodule
